// File: rtl/fixed_point_accumulator_pkg.sv
// Shared fixed-point definitions: default word/fraction widths and saturation limits.
// Used by the accumulator and reusable by FixedPointALU.
package fixed_point_accumulator_pkg;

  localparam int FP_N = 32;
  localparam int FP_Q = 20;

  localparam logic [FP_N-1:0] SAT_MAX = {1'b0, {(FP_N-1){1'b1}}};
  localparam logic [FP_N-1:0] SAT_MIN = {1'b1, {(FP_N-1){1'b0}}};

endpackage

// File: rtl/fixed_point_sat_add.sv
// Combinational two's-complement saturating adder; clamps the N+1-bit sum to the N-bit range.
module fixed_point_sat_add
  import fixed_point_accumulator_pkg::*;
#(
  parameter int N = FP_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic [N:0] wide;

  always_comb begin
    wide = {a[N-1], a} + {b[N-1], b};
    ovf  = wide[N] ^ wide[N-1];
    y    = wide[N-1:0];
    // The extra sign bit tells which way the sum escaped the range.
    if (ovf) begin
      y = wide[N] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Sums len beats of Q(N-Q-1).Q data with saturation, then holds the result until taken.
module fixed_point_accumulator
  import fixed_point_accumulator_pkg::*;
#(
  parameter int N = FP_N,
  parameter int Q = FP_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   len,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("fixed_point_accumulator: Q must lie in [0, N-1]");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] acc;
  logic [7:0]   remaining;
  logic [N-1:0] add_y;
  logic         add_ovf;
  logic         beat;

  fixed_point_sat_add #(.N(N)) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .y   (add_y),
    .ovf (add_ovf)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign sum       = acc;
  assign beat      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            overflow <= 1'b0;
            if (len != 8'd0) begin
              remaining <= len;
              state     <= ACCUM;
            end else begin
              remaining <= '0;
              state     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc       <= add_y;
            remaining <= remaining - 8'd1;
            if (add_ovf) begin
              overflow <= 1'b1;
            end
            if (remaining == 8'd1) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed bench for fixed_point_accumulator with hand-computed expected values.
module tb_fixed_point_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fixed_point_accumulator #(.N(32), .Q(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", sum, 32'h0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // Basic sum: 4 x 1.0
    do_start(8'd4);
    chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
    beat(32'h0010_0000);
    beat(32'h0010_0000);
    beat(32'h0010_0000);
    chk("basic_not_done", {31'd0, out_valid}, 32'd0);
    chk("basic_partial", sum, 32'h0030_0000);
    beat(32'h0010_0000);
    chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_sum", sum, 32'h0040_0000);
    chk("basic_ovf", {31'd0, overflow}, 32'd0);
    chk("basic_hold_ready", {31'd0, in_ready}, 32'd0);
    take();
    chk("basic_idle", {31'd0, out_valid}, 32'd0);

    // Cancellation
    do_start(8'd2);
    beat(32'hFFFF_E000);
    beat(32'h0000_2000);
    chk("cancel_valid", {31'd0, out_valid}, 32'd1);
    chk("cancel_sum", sum, 32'h0);
    chk("cancel_ovf", {31'd0, overflow}, 32'd0);
    take();

    // Positive saturation
    do_start(8'd2);
    beat(32'h7FF0_0000);
    beat(32'h0020_0000);
    chk("possat_sum", sum, 32'h7FFF_FFFF);
    chk("possat_ovf", {31'd0, overflow}, 32'd1);
    take();

    // Negative saturation
    do_start(8'd2);
    beat(32'h8010_0000);
    beat(32'hFFE0_0000);
    chk("negsat_sum", sum, 32'h8000_0000);
    chk("negsat_ovf", {31'd0, overflow}, 32'd1);
    take();

    // Sticky overflow: clamp then move back in range
    do_start(8'd3);
    chk("start_clears_ovf", {31'd0, overflow}, 32'd0);
    chk("start_clears_sum", sum, 32'h0);
    beat(32'h7FF0_0000);
    beat(32'h0020_0000);
    beat(32'hFFF0_0000);
    chk("sticky_sum", sum, 32'h7FEF_FFFF);
    chk("sticky_ovf", {31'd0, overflow}, 32'd1);
    take();

    // Backpressure: gaps on input, out_ready low for 5 cycles, start ignored in HOLD
    do_start(8'd3);
    beat(32'h0010_0000);
    step();
    step();
    chk("bp_gap_sum", sum, 32'h0010_0000);
    chk("bp_gap_ready", {31'd0, in_ready}, 32'd1);
    beat(32'h0020_0000);
    step();
    step();
    chk("bp_gap2_valid", {31'd0, out_valid}, 32'd0);
    beat(32'h0030_0000);
    start = 1'b1;
    len   = 8'd5;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_sum", sum, 32'h0060_0000);
      chk("bp_hold_ovf", {31'd0, overflow}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    len   = 8'd0;
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_handshake_start_ignored", {31'd0, in_ready}, 32'd0);
    chk("bp_sum_persists", sum, 32'h0060_0000);

    // len = 0
    do_start(8'd0);
    chk("len0_valid", {31'd0, out_valid}, 32'd1);
    chk("len0_sum", sum, 32'h0);
    chk("len0_ready", {31'd0, in_ready}, 32'd0);
    take();

    // start during ACCUM has no effect
    do_start(8'd2);
    beat(32'h0010_0000);
    start = 1'b1;
    len   = 8'd7;
    step();
    start = 1'b0;
    len   = 8'd0;
    chk("accum_start_sum", sum, 32'h0010_0000);
    chk("accum_start_ready", {31'd0, in_ready}, 32'd1);
    beat(32'h0010_0000);
    chk("accum_start_done", {31'd0, out_valid}, 32'd1);
    chk("accum_start_final", sum, 32'h0020_0000);
    take();

    // Reset mid-op
    do_start(8'd4);
    beat(32'h0010_0000);
    beat(32'h0010_0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);

    // rst has priority over start
    rst   = 1'b1;
    start = 1'b1;
    len   = 8'd1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    len   = 8'd0;
    chk("rst_prio_ready", {31'd0, in_ready}, 32'd0);

    // Fresh len=1 run yields in_data exactly
    do_start(8'd1);
    beat(32'h1234_5678);
    chk("fresh_valid", {31'd0, out_valid}, 32'd1);
    chk("fresh_sum", sum, 32'h1234_5678);
    chk("fresh_ovf", {31'd0, overflow}, 32'd0);
    take();
    chk("fresh_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_point_accumulator.md
FIXED_POINT_ACCUMULATOR -- requirements
Module: fixed_point_accumulator

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning total word width in bits.
REQ-002 The block SHALL have parameter Q, default 20, meaning fractional bits; all data are two's-complement Q(N-Q-1).Q.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begin a new accumulation; sampled only in IDLE.
REQ-006 The block SHALL have port len, input, 8 bits: number of input beats to sum; sampled with start.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data holds a valid ALU result.
REQ-008 The block SHALL have port in_data, input, N bits: operand from the upstream FixedPointALU result.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-010 The block SHALL have port sum, output, N bits: accumulated result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum is final and stable.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes sum.
REQ-013 The block SHALL have port overflow, output, 1 bit: saturation occurred during the current accumulation, sticky.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM, HOLD.
REQ-015 In IDLE, a cycle with start=1 and len!=0 SHALL clear acc and overflow to 0, load remaining=len, and move to ACCUM next cycle.
REQ-016 In IDLE, a cycle with start=1 and len=0 SHALL clear acc and overflow to 0 and move directly to HOLD with sum=0.
REQ-017 in_ready SHALL be 1 exactly when the state is ACCUM; a beat is accepted only when in_valid=1 and in_ready=1.
REQ-018 On each accepted beat, acc SHALL take sat(acc+in_data) and remaining SHALL decrement by 1.
REQ-019 Cycles with in_valid=0 in ACCUM SHALL leave acc and remaining unchanged, with no timeout.
REQ-020 The accepted beat with remaining=1 SHALL move the FSM to HOLD; out_valid SHALL assert the cycle after that beat, for a latency of 1.
REQ-021 Saturation rule: the N+1-bit sum SHALL be clamped to {0,1...1}, i.e. 0x7FFFFFFF, on positive overflow and to {1,0...0}, i.e. 0x80000000, on negative overflow.
REQ-022 Any clamp SHALL set overflow, which remains 1 until the next start or rst.
REQ-023 In HOLD, out_valid SHALL be 1 and sum and overflow SHALL be stable.
REQ-024 In HOLD, out_ready=1 SHALL move the FSM to IDLE in the next cycle.
REQ-025 sum SHALL continuously present acc in all states.
REQ-026 start SHALL be ignored in ACCUM and HOLD.
REQ-027 start asserted in the same cycle as the HOLD handshake SHALL be ignored; a new start is accepted in IDLE only.

Reset
REQ-028 rst=1 SHALL force, on the next edge and regardless of state, including mid-ACCUM: state=IDLE, acc=0, remaining=0, overflow=0.
REQ-029 Resulting outputs after reset SHALL be in_ready=0, out_valid=0, sum=0, overflow=0.
REQ-030 rst SHALL take priority over start and all handshakes.

Structure
REQ-031 N, Q, and the saturation constants SAT_MAX and SAT_MIN SHALL live in the shared fixed-point definitions header used by FixedPointALU.
REQ-032 FSM state encodings SHALL be localparams of this module.
REQ-033 Saturating addition SHALL be one combinational sub-module, fixed_point_sat_add (a, b -> y, ovf), reusable by the ALU.

Verification
REQ-034 Basic sum: start, len=4, four beats of 0x00100000 (1.0) -> sum=0x00400000, overflow=0, out_valid one cycle after the 4th beat.
REQ-035 Cancellation: len=2, beats 0xFFFFE000 then 0x00002000 -> sum=0x00000000, overflow=0.
REQ-036 Saturation: len=2, 0x7FF00000+0x00200000 -> sum=0x7FFFFFFF, overflow=1; len=2, 0x80100000+0xFFE00000 -> sum=0x80000000, overflow=1.
REQ-037 Backpressure: len=3 with in_valid gaps of 2 idle cycles, out_ready held low 5 cycles -> correct sum held stable, out_valid held 1, FSM returns to IDLE the cycle after out_ready=1.
REQ-038 Boundary: len=0 -> out_valid=1 next cycle with sum=0; start during ACCUM -> no effect on sum or remaining.
REQ-039 Reset mid-op: rst after 2 of 4 beats -> next cycle in_ready=0, sum=0, out_valid=0; a fresh len=1 run then yields in_data exactly.
